// File: rtl/serial_adder_n.sv
// ---------------------------------------------------------------------------
// serial_adder_n
//
// Bit-serial adder: adds two WIDTH-bit operands plus a carry-in, one bit per
// clock, LSB first, through a single full-adder slice and a registered carry.
// Latency is WIDTH cycles after the accepted start edge. Throughput is one
// operation per WIDTH+1 cycles.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, an extra 'sub' input selects a-b (operand B inverted and
//   carry-in forced to 1). carry=1 then means "no borrow".
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous reset, active low
//   start  in   request a new operation (sampled only while busy=0)
//   a, b   in   WIDTH-bit operands, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   sub    in   (SERIAL_ADDER_SUB_EN only) subtract select, captured with a/b
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when sum/carry/ovf have just been updated
//   sum    out  WIDTH-bit result, held until the next completion
//   carry  out  carry out of the MSB, held with sum
//   ovf    out  signed overflow (carry into MSB xor carry out), held with sum
// ---------------------------------------------------------------------------
module serial_adder_n #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic [WIDTH-1:0]   sum_sh_next;
  logic [CNT_W-1:0]   count;
  logic               c_reg;
  logic               s_bit, c_next, last_bit;

  // Operand B and carry-in as they are loaded on the start edge.
  logic [WIDTH-1:0]   b_load;
  logic               c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's complement subtraction: a + ~b + 1. cin is ignored when sub=1.
  assign b_load = sub ? ~b : b;
  assign c_load = sub | cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign busy = (state == RUN);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_next  = state;
    s_bit       = a_sh[0] ^ b_sh[0] ^ c_reg;
    c_next      = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_reg) | (b_sh[0] & c_reg);
    last_bit    = (state == RUN) && (count == CNT_W'(WIDTH - 1));
    // Shift-then-insert form keeps WIDTH=1 legal (no [0:1] style slice).
    sum_sh_next = sum_sh >> 1;
    sum_sh_next[WIDTH-1] = s_bit;

    case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath. The shift registers are plain flops (not a memory array), so
  // they take the asynchronous clear along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c_reg  <= 1'b0;
      count  <= '0;
      done   <= 1'b0;
      sum    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            c_reg <= c_load;
            count <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_sh_next;
          c_reg  <= c_next;
          count  <= count + CNT_W'(1);
          if (last_bit) begin
            // c_reg here is still the carry into the MSB slice.
            sum   <= sum_sh_next;
            carry <= c_next;
            ovf   <= c_reg ^ c_next;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_n
//
// Directed bench for serial_adder_n. An 8-bit instance covers the main
// addition cases, start-during-RUN, start-in-done-cycle and mid-RUN reset;
// a 1-bit instance covers the single-cycle corner. With SERIAL_ADDER_SUB_EN
// defined the subtract cases run as well. Expected results come from an
// arithmetic reference model and go through a queue that is popped at done.
// ---------------------------------------------------------------------------
module tb_serial_adder_n;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, carry, ovf;
  logic [7:0] sum;

  logic       start1;
  logic [0:0] a1, b1, sum1;
  logic       cin1;
  logic       busy1, done1, carry1, ovf1;

`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
  logic       sub1;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  serial_adder_n #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry),
    .ovf   (ovf)
  );

  serial_adder_n #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .carry (carry1),
    .ovf   (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width integer add; overflow from operand/result signs.
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv, input logic sv);
    exp_t       e;
    logic [7:0] bb;
    logic       ci;
    logic [8:0] full;
    bb      = sv ? ~bv : bv;
    ci      = sv ? 1'b1 : cv;
    full    = {1'b0, av} + {1'b0, bb} + {8'd0, ci};
    e.sum   = full[7:0];
    e.carry = full[8];
    e.ovf   = (av[7] == bb[7]) && (full[7] != av[7]);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv);
    a   = av;
    b   = bv;
    cin = cv;
`ifdef SERIAL_ADDER_SUB_EN
    sub = sv;
`endif
    start = 1'b1;
    tick;
    start = 1'b0;
    exp_q.push_back(model(av, bv, cv, sv));
  endtask

  // Waits for done (bounded), checks latency from the start edge and the
  // popped expectation. 'base' is the number of edges already spent since E0.
  task automatic wait_done(input string tag, input int base,
                           input logic chk_busy);
    int   lat;
    int   bcnt;
    logic got;
    exp_t e;
    lat  = base;
    bcnt = busy ? 1 : 0;
    got  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      lat++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bcnt++;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_latency"}, 64'(lat), 64'd8);
      if (chk_busy) check({tag, "_busy_cycles"}, 64'(bcnt), 64'd8);
      check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        last_exp = e;
        check({tag, "_sum"},   64'(sum),   64'(e.sum));
        check({tag, "_carry"}, 64'(carry), 64'(e.carry));
        check({tag, "_ovf"},   64'(ovf),   64'(e.ovf));
      end else begin
        check({tag, "_unexpected_done"}, 64'(exp_q.size()), 64'd1);
      end
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  // One idle edge after done: pulse ends, results hold.
  task automatic check_hold(input string tag);
    tick;
    check({tag, "_done_pulse_ends"}, 64'(done), 64'd0);
    check({tag, "_sum_held"},        64'(sum),  64'(last_exp.sum));
    check({tag, "_carry_held"},      64'(carry), 64'(last_exp.carry));
  endtask

  logic [7:0] ra, rb;
  logic       rc;
  int         done_cnt;
  logic [0:0] w_a, w_b;
  logic       w_c, w_s, w_co, w_ov;
  logic [1:0] w_full;

  initial begin
    rst_n  = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub    = 1'b0;
    sub1   = 1'b0;
`endif
    last_exp = '{sum: 8'h00, carry: 1'b0, ovf: 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) tick;
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_sum",   64'(sum),   64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_ovf",   64'(ovf),   64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    rst_n = 1'b1;
    tick;

    // Basic add with busy/latency profile
    launch(8'h0F, 8'h01, 1'b0, 1'b0);
    check("add0f_busy_after_start", 64'(busy), 64'd1);
    check("add0f_done_low_after_start", 64'(done), 64'd0);
    wait_done("add0f", 0, 1'b1);
    check_hold("add0f");

    // Carry out, then signed overflow
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    check("addff_sum_not_cleared", 64'(sum), 64'h10);
    wait_done("addff", 0, 1'b1);
    check_hold("addff");
    launch(8'h7F, 8'h00, 1'b1, 1'b0);
    wait_done("add7f", 0, 1'b0);
    launch(8'h80, 8'h80, 1'b0, 1'b0);
    wait_done("add80", 0, 1'b0);

    // A few random operands
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      launch(ra, rb, rc, 1'b0);
      wait_done($sformatf("rand%0d", i), 0, 1'b0);
    end

    // start during RUN is ignored; then start in the done cycle is accepted
    launch(8'h03, 8'h04, 1'b1, 1'b0);
    tick;
    tick;
    a     = 8'hAA;
    start = 1'b1;
    tick;
    start = 1'b0;
    a     = 8'h00;
    wait_done("ignore", 3, 1'b0);
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    check("backtoback_done_deasserts", 64'(done), 64'd0);
    check("backtoback_sum_kept", 64'(sum), 64'h08);
    check("backtoback_busy", 64'(busy), 64'd1);
    wait_done("backtoback", 0, 1'b1);
    done_cnt = 0;
    repeat (12) begin
      tick;
      if (done) done_cnt++;
    end
    check("no_extra_done", 64'(done_cnt), 64'd0);

    // Reset in the middle of RUN
    launch(8'h55, 8'h55, 1'b0, 1'b0);
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  64'(busy),  64'd0);
    check("midrst_done",  64'(done),  64'd0);
    check("midrst_sum",   64'(sum),   64'd0);
    check("midrst_carry", 64'(carry), 64'd0);
    check("midrst_ovf",   64'(ovf),   64'd0);
    void'(exp_q.pop_front());
    tick;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      tick;
      if (done) done_cnt++;
    end
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    launch(8'h55, 8'h55, 1'b0, 1'b0);
    wait_done("after_rst", 0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction
    launch(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done("sub05", 0, 1'b1);
    launch(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done("sub80", 0, 1'b0);
    launch(8'h40, 8'h40, 1'b0, 1'b1);
    wait_done("sub40", 0, 1'b0);
    sub = 1'b0;
`endif

    // WIDTH=1 instance: single RUN cycle
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin w_a = 1'b1; w_b = 1'b1; w_c = 1'b1; end
        1:       begin w_a = 1'b1; w_b = 1'b0; w_c = 1'b1; end
        2:       begin w_a = 1'b0; w_b = 1'b0; w_c = 1'b1; end
        default: begin w_a = 1'b1; w_b = 1'b1; w_c = 1'b0; end
      endcase
      w_full = {1'b0, w_a} + {1'b0, w_b} + {1'b0, w_c};
      w_s    = w_full[0];
      w_co   = w_full[1];
      w_ov   = (w_a == w_b) && (w_s != w_a[0]);
      a1     = w_a;
      b1     = w_b;
      cin1   = w_c;
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      check($sformatf("w1_%0d_busy", i), 64'(busy1), 64'd1);
      check($sformatf("w1_%0d_early_done", i), 64'(done1), 64'd0);
      tick;
      check($sformatf("w1_%0d_done", i),  64'(done1),  64'd1);
      check($sformatf("w1_%0d_sum", i),   64'(sum1),   64'(w_s));
      check($sformatf("w1_%0d_carry", i), 64'(carry1), 64'(w_co));
      check($sformatf("w1_%0d_ovf", i),   64'(ovf1),   64'(w_ov));
      tick;
      check($sformatf("w1_%0d_done_ends", i), 64'(done1), 64'd0);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
